perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised bank of performance counters for the pipelined CPU.
//  Channel 0 counts executed cycles and tracks halt (counts the halt cycle, then stops).
//  Channels 1..NUM_EV count per-cycle event strobes (jump, branch taken, load-use stall, ...).
//  Supports wrap or saturate mode, sticky overflow, clear, freeze and a registered readout mux.
// PARAMETERS
//  WIDTH   32  counter width, bits (>=2)
//  NUM_EV  3   number of event channels (>=1); total channels = NUM_EV+1
//  SEL_W   2   select width; must satisfy 2**SEL_W >= NUM_EV+1
//  SAT     0   0 = wrap at 2**WIDTH, 1 = saturate at 2**WIDTH-1
// PORTS
//  in_CLK     input   1          clock, rising edge
//  in_RST     input   1          reset, asynchronous, active-high
//  in_EN      input   1          CPU run enable (low = halted)
//  in_EV      input   NUM_EV     event strobes; bit i drives channel i+1
//  in_CLR     input   1          synchronous clear of all counters and flags
//  in_FREEZE  input   1          hold all counters, flags and halt state
//  in_SEL     input   SEL_W      readout channel: 0 = total, k = event k
//  out_data   output  WIDTH      registered value of selected channel
//  out_total  output  WIDTH      channel 0 counter, direct from register
//  out_ovf    output  NUM_EV+1   sticky overflow flags, bit k = channel k
//  out_halted output  1          1 while halt FSM in HALTED
// BEHAVIOUR
//  Reset: in_RST high -> immediately all counters, out_data, out_total, out_ovf = 0; FSM = RUN; out_halted = 0.
//  Priority per rising edge: in_CLR > in_FREEZE > normal update.
//  in_CLR: all counters and out_ovf -> 0, FSM -> RUN; out_data still loads (pre-clear value).
//  in_FREEZE (no CLR): counters, out_ovf, FSM hold; out_data still updates from held values.
//  Halt FSM (2 states), normal update:
//   RUN:    channel 0 increments every cycle; if !in_EN -> HALTED (that cycle still counted).
//   HALTED: if in_EN -> increment channel 0, -> RUN; else hold (no increment).
//   => EN high n cycles then low: total = n+1, then constant.
//  Event channel k (1..NUM_EV): increments when in_EV[k-1] = 1; independent of halt state.
//  Increment rule (all channels):
//   count < max: count+1.
//   count = max, SAT=0: count -> 0, out_ovf[k] set.
//   count = max, SAT=1: count holds max, out_ovf[k] set.
//   out_ovf bits sticky until in_CLR or in_RST.
//  Readout: out_data <= counter[in_SEL] (value before this edge's update); latency 1 cycle.
//   in_SEL > NUM_EV -> out_data <= 0.
//  out_total: combinational from channel 0 register (no extra latency).
//  Simultaneous events in one cycle: each channel increments by exactly 1 independently.
//  Reset mid-count: asynchronous clear wins; counting restarts on first edge after release.
// TESTING
//  1. Run, then pulse in_RST between edges -> all outputs 0 before the next edge; out_halted = 0.
//  2. in_EN=1 for 10 cycles, then 0 for 5 -> out_total = 11, out_halted = 1; EN=1 again -> out_total
//     increments on each of the next cycles; out_halted = 0.
//  3. in_EV=3'b101 for 4 cycles (NUM_EV=3) -> ch1 = 4, ch2 = 0, ch3 = 4;
//     in_SEL=1 -> out_data = 4 on the following cycle.
//  4. WIDTH=4: 17 pulses on in_EV[0] -> SAT=0: ch1 = 1, out_ovf[1] = 1; SAT=1: ch1 = 15, out_ovf[1] = 1.
//  5. in_CLR and in_FREEZE both high -> counters and out_ovf = 0. Then FREEZE alone 5 cycles,
//     with EN and events active -> no counter change; FSM state unchanged.
//  6. NUM_EV=2, SEL_W=2, in_SEL=3 -> out_data = 0 one cycle later; in_SEL=0 -> out_data = out_total
//     as it was one cycle earlier.

Source files
------------

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: a bank of performance counters for the pipelined CPU.
//   Channel 0 counts executed cycles. A two-state halt FSM counts the cycle
//   in which the CPU halts and then stops counting.
//   Channels 1..NUM_EV each count one per-cycle event strobe.
//   Every channel either wraps or saturates, and has a sticky overflow flag.
//   The bank supports a synchronous clear, a freeze, and a registered readout mux.
// Ports:
//   in_CLK, in_RST      clock (rising edge), async active-high reset
//   in_EN               CPU run enable (low = halted)
//   in_EV[NUM_EV]       event strobes, bit i -> channel i+1
//   in_CLR, in_FREEZE   clear (wins) / hold all state
//   in_SEL[SEL_W]       readout channel select
//   out_data[WIDTH]     registered value of the selected channel, 1-cycle latency
//   out_total[WIDTH]    channel 0 counter, direct from the register
//   out_ovf[NUM_EV+1]   sticky overflow flags
//   out_halted          halt FSM is in HALTED

// One counter channel: increment, wrap or saturate, sticky overflow flag.
module perf_counter_lane #(
  parameter int WIDTH = 32,
  parameter int SAT   = 0
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic             in_INC,
  input  logic             in_CLR,
  input  logic             in_FREEZE,
  output logic [WIDTH-1:0] out_cnt,
  output logic             out_ovf
);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (in_CLR) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (!in_FREEZE && in_INC) begin
      if (r_cnt == MAX) begin
        r_ovf <= 1'b1;
        // In saturate mode the counter simply keeps MAX.
        if (SAT == 0) r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_cnt = r_cnt;
  assign out_ovf = r_ovf;
endmodule

module perf_counter_bank #(
  parameter int WIDTH  = 32,
  parameter int NUM_EV = 3,
  parameter int SEL_W  = 2,
  parameter int SAT    = 0
) (
  input  logic              in_CLK,
  input  logic              in_RST,
  input  logic              in_EN,
  input  logic [NUM_EV-1:0] in_EV,
  input  logic              in_CLR,
  input  logic              in_FREEZE,
  input  logic [SEL_W-1:0]  in_SEL,
  output logic [WIDTH-1:0]  out_data,
  output logic [WIDTH-1:0]  out_total,
  output logic [NUM_EV:0]   out_ovf,
  output logic              out_halted
);
  localparam int NCH = NUM_EV + 1;
  localparam int NRD = 2 ** SEL_W;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t r_state, w_state_nxt;
  logic   w_inc0;

  // Halt FSM: state register. Clear forces RUN; freeze holds the state.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST)          r_state <= ST_RUN;
    else if (in_CLR)     r_state <= ST_RUN;
    else if (!in_FREEZE) r_state <= w_state_nxt;
  end

  // Halt FSM: next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (!in_EN) w_state_nxt = ST_HALT;
      ST_HALT: if (in_EN)  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Halt FSM: outputs. RUN counts every cycle, including the cycle that
  // halts. HALTED counts only the cycle in which EN returns.
  always_comb begin
    w_inc0     = 1'b0;
    out_halted = 1'b0;
    case (r_state)
      ST_RUN:  w_inc0 = 1'b1;
      ST_HALT: begin
        w_inc0     = in_EN;
        out_halted = 1'b1;
      end
      default: w_inc0 = 1'b0;
    endcase
  end

  logic [NCH-1:0]            w_inc;
  logic [NCH-1:0][WIDTH-1:0] w_cnt;

  assign w_inc = {in_EV, w_inc0};

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    perf_counter_lane #(.WIDTH(WIDTH), .SAT(SAT)) u_lane (
      .in_CLK    (in_CLK),
      .in_RST    (in_RST),
      .in_INC    (w_inc[k]),
      .in_CLR    (in_CLR),
      .in_FREEZE (in_FREEZE),
      .out_cnt   (w_cnt[k]),
      .out_ovf   (out_ovf[k])
    );
  end

  // The readout table is padded to the full select range. Selects beyond
  // the last channel therefore read zero without a separate range compare.
  logic [NRD-1:0][WIDTH-1:0] w_rd;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    if (k < NCH) begin : g_ch
      assign w_rd[k] = w_cnt[k];
    end else begin : g_zero
      assign w_rd[k] = '0;
    end
  end

  // Readout samples pre-update counter values. It loads even on clear or freeze.
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) r_data <= '0;
    else        r_data <= w_rd[in_SEL];
  end

  assign out_data  = r_data;
  assign out_total = w_cnt[0];
endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] ev = 3'b000;
  logic       clr = 1'b0;
  logic       frz = 1'b0;
  logic [1:0] sel = 2'd0;

  int checks = 0;
  int errors = 0;

  // a: 32-bit, 3 events, wrap
  logic [31:0] a_data, a_total;
  logic [3:0]  a_ovf;
  logic        a_halted;
  // w: 4-bit, 2 events, wrap
  logic [3:0]  w_data, w_total;
  logic [2:0]  w_ovf;
  logic        w_halted;
  // s: 4-bit, 2 events, saturate
  logic [3:0]  s_data, s_total;
  logic [2:0]  s_ovf;
  logic        s_halted;

  always #5 clk = ~clk;

  perf_counter_bank #(.WIDTH(32), .NUM_EV(3), .SEL_W(2), .SAT(0)) dut_a (
    .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_EV(ev), .in_CLR(clr),
    .in_FREEZE(frz), .in_SEL(sel), .out_data(a_data), .out_total(a_total),
    .out_ovf(a_ovf), .out_halted(a_halted));

  perf_counter_bank #(.WIDTH(4), .NUM_EV(2), .SEL_W(2), .SAT(0)) dut_w (
    .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_EV(ev[1:0]), .in_CLR(clr),
    .in_FREEZE(frz), .in_SEL(sel), .out_data(w_data), .out_total(w_total),
    .out_ovf(w_ovf), .out_halted(w_halted));

  perf_counter_bank #(.WIDTH(4), .NUM_EV(2), .SEL_W(2), .SAT(1)) dut_s (
    .in_CLK(clk), .in_RST(rst), .in_EN(en), .in_EV(ev[1:0]), .in_CLR(clr),
    .in_FREEZE(frz), .in_SEL(sel), .out_data(s_data), .out_total(s_total),
    .out_ovf(s_ovf), .out_halted(s_halted));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // reset state
    #3;
    check("rst_total", a_total, 0);
    check("rst_data", a_data, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_halted", a_halted, 0);
    en = 1'b1;
    #9 rst = 1'b0;

    // run 10 cycles, then halt
    tick(10);
    check("run10_total", a_total, 10);
    en = 1'b0;
    tick(5);
    check("halt_total", a_total, 11);
    check("halt_flag", a_halted, 1);
    en = 1'b1;
    tick();
    check("resume_total", a_total, 12);
    check("resume_halted", a_halted, 0);
    tick();
    check("resume_total2", a_total, 13);

    // async reset between edges, while halted
    en = 1'b0;
    tick();
    check("pre_rst_halted", a_halted, 1);
    rst = 1'b1;
    #2;
    check("midrst_total", a_total, 0);
    check("midrst_data", a_data, 0);
    check("midrst_halted", a_halted, 0);
    check("midrst_w_total", w_total, 0);
    rst = 1'b0;

    // events 101 for 4 cycles
    ev = 3'b101; sel = 2'd1;
    tick(4);
    ev = 3'b000;
    tick();
    check("ev_ch1", a_data, 4);
    sel = 2'd2;
    tick();
    check("ev_ch2", a_data, 0);
    sel = 2'd3;
    tick();
    check("ev_ch3", a_data, 4);
    check("w_sel_oob", w_data, 0);
    check("ev_total", a_total, 1);

    // clear loads pre-clear readout, then 17 pulses on ev[0]
    sel = 2'd1; clr = 1'b1;
    tick();
    check("clr_data_preclear", a_data, 4);
    clr = 1'b0;
    ev = 3'b001;
    tick(17);
    ev = 3'b000;
    tick();
    check("a_ch1_17", a_data, 17);
    check("a_ovf_none", a_ovf, 0);
    check("wrap_ch1", w_data, 1);
    check("wrap_ovf", w_ovf, 3'b010);
    check("sat_ch1", s_data, 15);
    check("sat_ovf", s_ovf, 3'b010);

    // clear beats freeze
    clr = 1'b1; frz = 1'b1; en = 1'b1; ev = 3'b111;
    tick();
    check("clrfrz_total", a_total, 0);
    check("clrfrz_w_ovf", w_ovf, 0);
    check("clrfrz_s_ovf", s_ovf, 0);
    clr = 1'b0; frz = 1'b0; en = 1'b0; ev = 3'b000;
    tick();
    check("prefrz_total", a_total, 1);
    check("prefrz_halted", a_halted, 1);

    // freeze for 5 cycles with EN and events active
    frz = 1'b1; en = 1'b1; ev = 3'b111; sel = 2'd2;
    tick(5);
    check("frz_total", a_total, 1);
    check("frz_halted", a_halted, 1);
    check("frz_ch2", a_data, 0);
    frz = 1'b0; ev = 3'b000;
    tick();
    check("unfrz_total", a_total, 2);
    check("unfrz_halted", a_halted, 0);

    // sel 0 on the narrow bank, then an out-of-range select
    sel = 2'd0;
    tick();
    check("w_sel0_data", w_data, 2);
    check("w_total3", w_total, 3);
    sel = 2'd3;
    tick();
    check("w_sel3_data", w_data, 0);

    // channel 0 wrap vs saturate at 4 bits
    tick(12);
    check("w_total_wrap", w_total, 0);
    check("w_ovf0", w_ovf, 3'b001);
    check("s_total_sat", s_total, 15);
    check("s_ovf0", s_ovf, 3'b001);

    // simultaneous events
    ev = 3'b111;
    tick(2);
    ev = 3'b000;
    tick();
    check("simul_ch3", a_data, 2);
    sel = 2'd1;
    tick();
    check("simul_ch1", a_data, 2);
    check("simul_w_ch1", w_data, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
